// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: IF/ID state encoding, NOP word, rs/rt field positions
package cpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } ifid_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use / busy stall and bubble generation for the ID stage
module hazard_detect (
  input  logic       valid,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       busy,
  input  logic       flush,
  output logic       stall,
  output logic       bubble
);

  logic load_use;

  // r0 is hardwired zero, so a load targeting it can never create a dependency
  assign load_use = ex_mem_read & valid & (ex_rt != 5'd0) & ((ex_rt == rs) | (ex_rt == rt));

  assign stall  = (load_use | busy) & ~flush;
  assign bubble = load_use & ~flush;

endmodule

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID pipeline register with stall/flush; counters built only with IFID_PERF_CNT_EN
module if_id_pipe
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] npc_i,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        busy_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  ifid_state_e state_q, state_d;
  logic [31:0] pc_q, npc_q, hold_q;
  logic        valid_q;
  logic [31:0] instr_sel;

  // The synchronous ROM re-reads the held IF PC while stalled, so the ID word must come from hold_q
  assign instr_sel = (state_q == HELD) ? hold_q : instr_i;
  assign instr_o   = valid_q ? instr_sel : NOP;
  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign npc_o     = npc_q;

  hazard_detect u_hazard_detect (
    .valid       (valid_q),
    .rs          (instr_o[RS_MSB:RS_LSB]),
    .rt          (instr_o[RT_MSB:RT_LSB]),
    .ex_mem_read (ex_mem_read_i),
    .ex_rt       (ex_rt_i),
    .busy        (busy_i),
    .flush       (flush_i),
    .stall       (stall_o),
    .bubble      (bubble_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i)      state_d = RUN;
    else if (stall_o) state_d = HELD;
    else              state_d = RUN;
  end

  // stall_o is already masked by flush_i, so the non-stalled branch also covers flush
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= 32'd0;
      npc_q   <= 32'd0;
      hold_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (!stall_o) begin
      pc_q    <= pc_i;
      npc_q   <= npc_i;
      valid_q <= ~flush_i;
    end else if (state_q == RUN) begin
      hold_q  <= instr_i;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - table-driven scoreboard bench for if_id_pipe (counter checks follow IFID_PERF_CNT_EN)
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i, npc_i, instr_i;
  logic        flush_i, ex_mem_read_i, busy_i;
  logic [4:0]  ex_rt_i;
  logic        stall_o, bubble_o, valid_o;
  logic [31:0] pc_o, npc_o, instr_o, stall_cnt_o, flush_cnt_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  if_id_pipe dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .npc_i(npc_i), .instr_i(instr_i),
    .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i), .busy_i(busy_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .pc_o(pc_o), .npc_o(npc_o), .instr_o(instr_o),
    .valid_o(valid_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        busy;
    logic        exmr;
    logic [4:0]  exrt;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic [31:0] e_instr;
    logic        e_v;
    logic        e_stall;
    logic        e_bub;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  // IMEM image: lw-style word, rs=8 at 0x10, rs=0 at 0x88, rs=5 elsewhere, rt=3, low half = address
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [4:0] rs;
    rs = (a == 32'h10) ? 5'd8 : (a == 32'h88) ? 5'd0 : 5'd5;
    return {6'h23, rs, 5'd3, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic v(input logic [31:0] pc, input logic fl, input logic bz, input logic mr,
                   input logic [4:0] rt, input logic [31:0] epc, input logic ev,
                   input logic est, input logic ebu);
    vec_t r;
    r.pc = pc; r.flush = fl; r.busy = bz; r.exmr = mr; r.exrt = rt;
    r.e_pc = epc; r.e_npc = epc + 32'd4; r.e_v = ev;
    r.e_instr = ev ? rom(epc) : 32'h0;
    r.e_stall = est; r.e_bub = ebu;
    vecs.push_back(r);
  endtask

  initial begin
    logic [31:0] prev_pc;
    vec_t e;
    int   idx;

    rst_i = 1'b0; pc_i = 0; npc_i = 4; instr_i = 0;
    flush_i = 0; ex_mem_read_i = 0; ex_rt_i = 0; busy_i = 0;

    //        pc       fl bz mr rt   e_pc     ev st bu
    v(32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    v(32'h04, 0, 0, 0, 0, 32'h00, 1, 0, 0);
    v(32'h08, 0, 0, 0, 0, 32'h04, 1, 0, 0);
    v(32'h0C, 0, 0, 0, 0, 32'h08, 1, 0, 0);
    v(32'h10, 0, 0, 0, 0, 32'h0C, 1, 0, 0);
    v(32'h14, 0, 0, 1, 8, 32'h10, 1, 1, 1);
    v(32'h14, 0, 0, 0, 0, 32'h10, 1, 0, 0);
    v(32'h18, 0, 0, 0, 0, 32'h14, 1, 0, 0);
    v(32'h1C, 0, 1, 0, 0, 32'h18, 1, 1, 0);
    for (int k = 0; k < 4; k++) v(32'h1C, 0, 1, 0, 0, 32'h18, 1, 1, 0);
    v(32'h1C, 0, 0, 0, 0, 32'h18, 1, 0, 0);
    v(32'h20, 0, 0, 0, 0, 32'h1C, 1, 0, 0);
    v(32'h80, 1, 1, 0, 0, 32'h20, 1, 0, 0);
    v(32'h84, 0, 0, 0, 0, 32'h80, 0, 0, 0);
    v(32'h88, 0, 0, 0, 0, 32'h84, 1, 0, 0);
    v(32'h8C, 0, 0, 1, 0, 32'h88, 1, 0, 0);
    v(32'h90, 0, 0, 1, 3, 32'h8C, 1, 1, 1);
    v(32'h90, 0, 0, 0, 0, 32'h8C, 1, 0, 0);
    v(32'h94, 0, 0, 0, 0, 32'h90, 1, 0, 0);
    v(32'hA0, 1, 0, 1, 3, 32'h94, 1, 0, 0);
    v(32'hA4, 0, 0, 1, 3, 32'hA0, 0, 0, 0);
    v(32'hA8, 0, 0, 0, 0, 32'hA4, 1, 0, 0);
    v(32'hAC, 0, 1, 0, 0, 32'hA8, 1, 1, 0);
    vecs[0].e_npc = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_pc", pc_o, 0);       chk("rst_npc", npc_o, 0);
    chk("rst_instr", instr_o, 0); chk("rst_valid", 32'(valid_o), 0);
    chk("rst_stall", 32'(stall_o), 0); chk("rst_bubble", 32'(bubble_o), 0);
    chk("rst_scnt", stall_cnt_o, 0);   chk("rst_fcnt", flush_cnt_o, 0);

    prev_pc = 32'h0;
    @(negedge clk);
    rst_i = 1'b1;
    idx = 0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      pc_i = vecs[i].pc; npc_i = vecs[i].pc + 32'd4; instr_i = rom(prev_pc);
      flush_i = vecs[i].flush; busy_i = vecs[i].busy;
      ex_mem_read_i = vecs[i].exmr; ex_rt_i = vecs[i].exrt;
      prev_pc = vecs[i].pc;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", idx), pc_o, e.e_pc);
      chk($sformatf("v%0d_npc", idx), npc_o, e.e_npc);
      chk($sformatf("v%0d_instr", idx), instr_o, e.e_instr);
      chk($sformatf("v%0d_valid", idx), 32'(valid_o), 32'(e.e_v));
      chk($sformatf("v%0d_stall", idx), 32'(stall_o), 32'(e.e_stall));
      chk($sformatf("v%0d_bubble", idx), 32'(bubble_o), 32'(e.e_bub));
      idx++;
    end

    // last vector stalls on busy, so the front end is now HELD holding the word at 0xA8
    @(negedge clk);
    busy_i = 1'b0; flush_i = 1'b0; ex_mem_read_i = 1'b0;
    #1;
`ifdef IFID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt_o, 32'd8);
    chk("flush_cnt", flush_cnt_o, 32'd2);
`else
    chk("stall_cnt_tied", stall_cnt_o, 32'd0);
    chk("flush_cnt_tied", flush_cnt_o, 32'd0);
`endif
    chk("held_instr", instr_o, rom(32'hA8));
    rst_i = 1'b0;
    #1;
    chk("mid_rst_pc", pc_o, 0);       chk("mid_rst_npc", npc_o, 0);
    chk("mid_rst_instr", instr_o, 0); chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_stall", 32'(stall_o), 0); chk("mid_rst_bubble", 32'(bubble_o), 0);
    chk("mid_rst_scnt", stall_cnt_o, 0);   chk("mid_rst_fcnt", flush_cnt_o, 0);

    @(negedge clk);
    rst_i = 1'b1; pc_i = 32'h200; npc_i = 32'h204; instr_i = rom(32'hAC);
    #1;
    chk("post_rst_valid", 32'(valid_o), 0);
    chk("post_rst_instr", instr_o, 0);
    chk("post_rst_pc", pc_o, 0);
    @(negedge clk);
    pc_i = 32'h204; npc_i = 32'h208; instr_i = rom(32'h200);
    #1;
    chk("resume_pc", pc_o, 32'h200);
    chk("resume_npc", npc_o, 32'h204);
    chk("resume_instr", instr_o, rom(32'h200));
    chk("resume_valid", 32'(valid_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: pc_i  in  32  current fetch PC from IF; npc_i  in  32  fetch PC+4 from IF.
REQ-004 SHALL have: instr_i  in  32  IMEM read data, valid the cycle after its PC was presented (synchronous ROM).
REQ-005 SHALL have: flush_i  in  1  taken branch/jump resolved in ID (pc_sel != 0).
REQ-006 SHALL have: ex_mem_read_i  in  1  EX-stage instruction is a load; ex_rt_i  in  5  its destination register.
REQ-007 SHALL have: busy_i  in  1  multi-cycle unit (mult/div) busy, hold front end.
REQ-008 SHALL have: stall_o  out  1  to IF stall_i; bubble_o  out  1  ID/EX inserts NOP.
REQ-009 SHALL have: pc_o  out  32; npc_o  out  32; instr_o  out  32; valid_o  out  1  ID-stage instruction qualifier.
REQ-010 SHALL have: stall_cnt_o  out  32; flush_cnt_o  out  32  performance counters (see Configuration).

Function
REQ-011 SHALL register pc_i/npc_i into pc_q/npc_q on every edge where stall_o=0, so pc_q pairs with instr_i of the following cycle.
REQ-012 SHALL implement FSM states RUN and HELD; RUN: instr_o = instr_i (bypass); HELD: instr_o = hold_q.
REQ-013 SHALL, in RUN with stall_o=1 at an edge, capture instr_i into hold_q, hold pc_q/npc_q, and go to HELD.
REQ-014 SHALL, in HELD with stall_o=1, keep pc_q, npc_q, hold_q unchanged and stay in HELD.
REQ-015 SHALL, in HELD with stall_o=0 at an edge, load pc_i/npc_i into pc_q/npc_q and go to RUN.
REQ-016 SHALL compute load-use = ex_mem_read_i & valid_o & (ex_rt_i != 0) & (ex_rt_i == instr_o[25:21] | ex_rt_i == instr_o[20:16]).
REQ-017 SHALL drive stall_o = (load-use | busy_i) & ~flush_i, combinationally; bubble_o = load-use & ~flush_i.
REQ-018 SHALL, on an edge with flush_i=1, clear valid_q to 0, go to RUN, and load pc_i/npc_i; flush has priority over stall.
REQ-019 SHALL set valid_q to 1 on any non-stalled, non-flushed edge; valid_q unchanged in stalled cycles.
REQ-020 SHALL force instr_o = 32'h0000_0000 (NOP) whenever valid_o=0.
REQ-021 SHALL give valid_o = valid_q; zero added latency beyond the single register stage.

Reset
REQ-022 SHALL, while rst_i=0, asynchronously force pc_q=0, npc_q=0, hold_q=0, valid_q=0, state=RUN, counters=0.
REQ-023 SHALL therefore present pc_o=0, npc_o=0, instr_o=0, valid_o=0, stall_o=0, bubble_o=0 during reset.
REQ-024 SHALL, on reset assertion mid-HELD, discard hold_q and resume in RUN after release with valid_o=0 for the first cycle.

Configuration
REQ-025 SHALL compile counters only when macro IFID_PERF_CNT_EN is defined: stall_cnt_o +1 per stalled edge, flush_cnt_o +1 per flush edge, both wrap at 2^32.
REQ-026 SHALL, without IFID_PERF_CNT_EN, keep the ports and tie stall_cnt_o and flush_cnt_o to 0 with no counter flops.

Structure
REQ-027 SHALL take state encoding (RUN=0, HELD=1), NOP constant and rs/rt field bit positions from shared package cpu_pkg.
REQ-028 SHALL contain one natural sub-module, hazard_detect, holding the combinational logic of REQ-016/REQ-017.

Verification
REQ-029 Sequential fetch, pc_i 0,4,8 -> pc_o 0,4 one cycle later, instr_o = word at each pc_o, valid_o=1.
REQ-030 EX lw ex_rt_i=8, ID instr rs=8 -> stall_o=1 and bubble_o=1 for one cycle, instr_o held, next cycle resumes with correct pc_o+4 pairing.
REQ-031 busy_i high 5 cycles -> pc_o/instr_o constant 5 cycles, stall_cnt_o +5 (with IFID_PERF_CNT_EN), correct instruction after release.
REQ-032 flush_i with busy_i simultaneously -> stall_o=0, next cycle valid_o=0 and instr_o=0, flush_cnt_o +1.
REQ-033 ex_rt_i=0 with ex_mem_read_i=1 and rs=0 -> no stall.
REQ-034 rst_i low during HELD -> all outputs 0 immediately; after release first valid_o=0, then normal fetch from pc_i.
